// File: rtl/sw_ctrl.sv
// -----------------------------------------------------------------------------
// sw_ctrl -- stopwatch control FSM.
//
// Turns four debounced pushbutton levels into single-cycle press events,
// sequences the centisecond counter through IDLE / RUN / PAUSE, arbitrates the
// lap register file between record (write) and recall (read), and drives the
// status LEDs.
//
// Parameters
//   CLK_DIV : clk cycles per counter tick (>= 2)
//   NREGS   : number of implemented lap registers (<= 16)
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_stop          : button level, rising edge = start/stop press
//   pause_resume        : button level, rising edge = pause/resume press
//   record_recall       : button level, rising edge = record/recall press
//   recall_mode         : button level, rising edge = toggle record/recall mode
//   reg_address[3:0]    : lap register address from the switches
//   cnt_full            : datapath counter is at its maximum
//   cnt_tick            : one-cycle counter increment pulse
//   cnt_clr             : one-cycle counter clear pulse (first cycle of RUN)
//   wr_en, wr_addr[3:0] : one-cycle lap write strobe and its address
//   rd_addr[3:0]        : latched lap read address
//   sel_recall          : 1 = display lap register at rd_addr, 0 = live count
//   reg_exceed          : combinational, reg_address >= NREGS
//   started_LED, paused_LED, write_LED, mode_LED : status LEDs
// -----------------------------------------------------------------------------
module sw_ctrl #(
  parameter int CLK_DIV = 500000,
  parameter int NREGS   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       pause_resume,
  input  logic       record_recall,
  input  logic       recall_mode,
  input  logic [3:0] reg_address,
  input  logic       cnt_full,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output logic [3:0] rd_addr,
  output logic       sel_recall,
  output logic       reg_exceed,
  output logic       started_LED,
  output logic       paused_LED,
  output logic       write_LED,
  output logic       mode_LED
);

  localparam int             PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [4:0]     NREGS_W   = 5'(NREGS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef enum logic [2:0] {ACT_NONE, ACT_START, ACT_PAUSE, ACT_RECORD, ACT_MODE} act_t;

  // Button bit order: 0 start, 1 pause, 2 record, 3 mode.
  logic [3:0]    smp;
  logic [3:0]    hist;
  logic [3:0]    press;
  act_t          act;
  logic          run_ctl;
  state_t        state;
  logic [PW-1:0] presc;
  logic          mode;

  assign press      = smp & ~hist;
  assign reg_exceed = ({1'b0, reg_address} >= NREGS_W);
  assign mode_LED   = mode;

  // Pick the single highest-priority press; the rest are dropped this cycle.
  // NOTE: every variable in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    act = ACT_NONE;
    if      (press[0]) act = ACT_START;
    else if (press[1]) act = ACT_PAUSE;
    else if (press[2]) act = ACT_RECORD;
    else if (press[3]) act = ACT_MODE;
  end

  // A start/pause press that actually changes the run state; only these clear
  // the recall selection and the write flag. Pause in IDLE, or resume while the
  // counter is saturated, is ignored.
  always_comb begin
    run_ctl = 1'b0;
    if (act == ACT_START)
      run_ctl = 1'b1;
    else if (act == ACT_PAUSE)
      run_ctl = (state == RUN) || (state == PAUSE && !cnt_full);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset to 1 so a button held through reset is not seen as a press.
      smp         <= 4'hF;
      hist        <= 4'hF;
      state       <= IDLE;
      presc       <= '0;
      mode        <= 1'b0;
      cnt_tick    <= 1'b0;
      cnt_clr     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      sel_recall  <= 1'b0;
      started_LED <= 1'b0;
      paused_LED  <= 1'b0;
      write_LED   <= 1'b0;
    end else begin
      smp  <= {recall_mode, record_recall, pause_resume, start_stop};
      hist <= smp;

      // Strobes default low so each is exactly one cycle wide.
      cnt_tick <= 1'b0;
      cnt_clr  <= 1'b0;
      wr_en    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (act == ACT_START) begin
            state       <= RUN;
            started_LED <= 1'b1;
            paused_LED  <= 1'b0;
            cnt_clr     <= 1'b1;
            presc       <= '0;
          end
        end
        RUN: begin
          // Prescaler is frozen on any exit edge so a paused run keeps its
          // partial tick and a saturated counter sees no extra tick.
          if (act == ACT_START) begin
            state       <= IDLE;
            started_LED <= 1'b0;
            paused_LED  <= 1'b0;
          end else if (cnt_full || act == ACT_PAUSE) begin
            state      <= PAUSE;
            paused_LED <= 1'b1;
          end else if (presc == PRESC_MAX) begin
            presc    <= '0;
            cnt_tick <= 1'b1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        PAUSE: begin
          if (act == ACT_START) begin
            state       <= IDLE;
            started_LED <= 1'b0;
            paused_LED  <= 1'b0;
          end else if (act == ACT_PAUSE && !cnt_full) begin
            state      <= RUN;
            paused_LED <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          started_LED <= 1'b0;
          paused_LED  <= 1'b0;
        end
      endcase

      if (run_ctl) begin
        sel_recall <= 1'b0;
        write_LED  <= 1'b0;
      end

      if (act == ACT_RECORD && !reg_exceed) begin
        if (!mode) begin
          wr_en     <= 1'b1;
          wr_addr   <= reg_address;
          write_LED <= 1'b1;
        end else begin
          rd_addr    <= reg_address;
          sel_recall <= 1'b1;
        end
      end

      if (act == ACT_MODE) begin
        mode       <= ~mode;
        sel_recall <= 1'b0;
        write_LED  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_ctrl -- self-checking bench for sw_ctrl (CLK_DIV = 10, NREGS = 10).
//
// Strobe outputs (cnt_clr, cnt_tick, wr_en/wr_addr) are checked by a
// scoreboard: each scenario pushes the cycle (and address) at which a pulse is
// due, and a negedge monitor pops and compares every pulse the DUT produces.
// Level outputs are compared inline in each scenario task.
// -----------------------------------------------------------------------------
module tb_sw_ctrl;

  localparam int CLK_DIV = 10;
  localparam int NREGS   = 10;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_PAUSE = 4'b0010;
  localparam logic [3:0] B_REC   = 4'b0100;
  localparam logic [3:0] B_MODE  = 4'b1000;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
  } wr_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] reg_address;
  logic       cnt_full;
  logic       cnt_tick, cnt_clr, wr_en, sel_recall, reg_exceed;
  logic [3:0] wr_addr, rd_addr;
  logic       started_LED, paused_LED, write_LED, mode_LED;

  wr_exp_t exp_wr[$];
  int      exp_clr[$];
  int      exp_tick[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  sw_ctrl #(.CLK_DIV(CLK_DIV), .NREGS(NREGS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_stop   (btn[0]),
    .pause_resume (btn[1]),
    .record_recall(btn[2]),
    .recall_mode  (btn[3]),
    .reg_address  (reg_address),
    .cnt_full     (cnt_full),
    .cnt_tick     (cnt_tick),
    .cnt_clr      (cnt_clr),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .sel_recall   (sel_recall),
    .reg_exceed   (reg_exceed),
    .started_LED  (started_LED),
    .paused_LED   (paused_LED),
    .write_LED    (write_LED),
    .mode_LED     (mode_LED)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge; stable when sampled at negedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the strobe outputs.
  always @(negedge clk) begin
    wr_exp_t e;
    int      c;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_en_pulse: unexpected wr_en at cycle %0d addr %0d, required none", cyc, wr_addr);
      end else begin
        e = exp_wr.pop_front();
        if (e.cyc !== cyc || e.addr !== wr_addr) begin
          errors++;
          $display("FAIL wr_en_pulse: got cycle %0d addr %0d, required cycle %0d addr %0d", cyc, wr_addr, e.cyc, e.addr);
        end
      end
    end
    if (cnt_clr === 1'b1) begin
      checks++;
      if (exp_clr.size() == 0) begin
        errors++;
        $display("FAIL cnt_clr_pulse: unexpected cnt_clr at cycle %0d, required none", cyc);
      end else begin
        c = exp_clr.pop_front();
        if (c !== cyc) begin
          errors++;
          $display("FAIL cnt_clr_pulse: got cycle %0d, required cycle %0d", cyc, c);
        end
      end
    end
    if (cnt_tick === 1'b1) begin
      checks++;
      if (exp_tick.size() == 0) begin
        errors++;
        $display("FAIL cnt_tick_pulse: unexpected cnt_tick at cycle %0d, required none", cyc);
      end else begin
        c = exp_tick.pop_front();
        if (c !== cyc) begin
          errors++;
          $display("FAIL cnt_tick_pulse: got cycle %0d, required cycle %0d", cyc, c);
        end
      end
    end
  end

  // Press a button set: rise at a negedge (captured at edge k), acted on at
  // edge k+1 = act. Returns at the negedge after edge act.
  task automatic press(input logic [3:0] mask, input bit want_clr,
                       input bit want_wr, input logic [3:0] wr_a, output int act);
    wr_exp_t e;
    @(negedge clk);
    btn = btn | mask;
    act = cyc + 2;
    if (want_clr) exp_clr.push_back(act);
    if (want_wr) begin
      e.cyc  = act;
      e.addr = wr_a;
      exp_wr.push_back(e);
    end
    @(negedge clk);
    btn = btn & ~mask;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    btn         = 4'b0;
    reg_address = 4'd0;
    cnt_full    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cnt_tick, cnt_clr, wr_en, wr_addr, rd_addr, sel_recall, reg_exceed,
         started_LED, paused_LED, write_LED, mode_LED} !== 17'b0) begin
      errors++;
      $display("FAIL reset_state: got %b, required all zero",
               {cnt_tick, cnt_clr, wr_en, wr_addr, rd_addr, sel_recall, reg_exceed,
                started_LED, paused_LED, write_LED, mode_LED});
    end
  endtask

  task automatic test_start_tick_stop();
    int a, s;
    press(B_START, 1'b1, 1'b0, 4'd0, a);
    for (int i = 1; i <= 3; i++) exp_tick.push_back(a + i * CLK_DIV);
    checks++;
    if (started_LED !== 1'b1 || paused_LED !== 1'b0) begin
      errors++;
      $display("FAIL run_leds: got started %b paused %b, required 1 0", started_LED, paused_LED);
    end
    repeat (31) @(negedge clk);
    press(B_START, 1'b0, 1'b0, 4'd0, s);
    checks++;
    if (started_LED !== 1'b0) begin
      errors++;
      $display("FAIL stop_led: got started %b, required 0", started_LED);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || exp_clr.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL start_stop_drain: pending tick %0d clr %0d wr %0d, required 0 0 0",
               exp_tick.size(), exp_clr.size(), exp_wr.size());
    end
  endtask

  task automatic test_pause_resume();
    int b, p, r, s;
    press(B_START, 1'b1, 1'b0, 4'd0, b);
    checks++;
    if (paused_LED !== 1'b0) begin
      errors++;
      $display("FAIL pre_pause_led: got %b, required 0", paused_LED);
    end
    // Pause lands on edge b+7, with the prescaler holding 6.
    repeat (4) @(negedge clk);
    press(B_PAUSE, 1'b0, 1'b0, 4'd0, p);
    checks++;
    if (p !== b + 7 || paused_LED !== 1'b1 || started_LED !== 1'b1) begin
      errors++;
      $display("FAIL pause_enter: got act %0d paused %b started %b, required %0d 1 1",
               p, paused_LED, started_LED, b + 7);
    end
    repeat (47) @(negedge clk);
    checks++;
    if (paused_LED !== 1'b1) begin
      errors++;
      $display("FAIL pause_hold: got paused %b, required 1", paused_LED);
    end
    press(B_PAUSE, 1'b0, 1'b0, 4'd0, r);
    exp_tick.push_back(r + 4);
    exp_tick.push_back(r + 4 + CLK_DIV);
    checks++;
    if (paused_LED !== 1'b0 || started_LED !== 1'b1) begin
      errors++;
      $display("FAIL resume_leds: got paused %b started %b, required 0 1", paused_LED, started_LED);
    end
    repeat (15) @(negedge clk);
    press(B_START, 1'b0, 1'b0, 4'd0, s);
    repeat (12) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || exp_clr.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL pause_resume_drain: pending tick %0d clr %0d wr %0d, required 0 0 0",
               exp_tick.size(), exp_clr.size(), exp_wr.size());
    end
  endtask

  task automatic test_record();
    int w;
    logic [3:0] addrs [3];
    logic       exc   [3];
    addrs = '{4'd9, 4'd10, 4'd12};
    exc   = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    reg_address = 4'd3;
    press(B_REC, 1'b0, 1'b1, 4'd3, w);
    checks++;
    if (write_LED !== 1'b1) begin
      errors++;
      $display("FAIL write_led_set: got %b, required 1", write_LED);
    end
    for (int i = 0; i < 3; i++) begin
      reg_address = addrs[i];
      #1;
      checks++;
      if (reg_exceed !== exc[i]) begin
        errors++;
        $display("FAIL reg_exceed_%0d: got %b, required %b", addrs[i], reg_exceed, exc[i]);
      end
    end
    press(B_REC, 1'b0, 1'b0, 4'd0, w);
    repeat (3) @(negedge clk);
    checks++;
    if (write_LED !== 1'b1 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL record_exceed: got write_LED %b pending wr %0d, required 1 0", write_LED, exp_wr.size());
    end
  endtask

  task automatic test_recall();
    int a;
    press(B_MODE, 1'b0, 1'b0, 4'd0, a);
    checks++;
    if (mode_LED !== 1'b1 || write_LED !== 1'b0) begin
      errors++;
      $display("FAIL mode_on: got mode %b write %b, required 1 0", mode_LED, write_LED);
    end
    press(B_START, 1'b1, 1'b0, 4'd0, a);
    reg_address = 4'd5;
    press(B_REC, 1'b0, 1'b0, 4'd0, a);
    checks++;
    if (sel_recall !== 1'b1 || rd_addr !== 4'd5) begin
      errors++;
      $display("FAIL recall_latch: got sel %b rd_addr %0d, required 1 5", sel_recall, rd_addr);
    end
    reg_address = 4'd7;
    @(negedge clk);
    checks++;
    if (rd_addr !== 4'd5 || sel_recall !== 1'b1) begin
      errors++;
      $display("FAIL recall_hold: got sel %b rd_addr %0d, required 1 5", sel_recall, rd_addr);
    end
    press(B_PAUSE, 1'b0, 1'b0, 4'd0, a);
    checks++;
    if (sel_recall !== 1'b0 || paused_LED !== 1'b1 || rd_addr !== 4'd5) begin
      errors++;
      $display("FAIL pause_clears_recall: got sel %b paused %b rd_addr %0d, required 0 1 5",
               sel_recall, paused_LED, rd_addr);
    end
    reg_address = 4'd12;
    press(B_REC, 1'b0, 1'b0, 4'd0, a);
    checks++;
    if (sel_recall !== 1'b0 || rd_addr !== 4'd5) begin
      errors++;
      $display("FAIL recall_exceed: got sel %b rd_addr %0d, required 0 5", sel_recall, rd_addr);
    end
    press(B_START, 1'b0, 1'b0, 4'd0, a);
    press(B_MODE, 1'b0, 1'b0, 4'd0, a);
    checks++;
    if (started_LED !== 1'b0 || mode_LED !== 1'b0) begin
      errors++;
      $display("FAIL recall_exit: got started %b mode %b, required 0 0", started_LED, mode_LED);
    end
  endtask

  task automatic test_simultaneous();
    int a;
    reg_address = 4'd3;
    press(B_START | B_REC, 1'b1, 1'b0, 4'd0, a);
    checks++;
    if (started_LED !== 1'b1 || write_LED !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: got started %b write %b, required 1 0", started_LED, write_LED);
    end
    press(B_START, 1'b0, 1'b0, 4'd0, a);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_clr.size() != 0 || exp_wr.size() != 0 || started_LED !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous_drain: pending clr %0d wr %0d started %b, required 0 0 0",
               exp_clr.size(), exp_wr.size(), started_LED);
    end
  endtask

  task automatic test_saturation_reset();
    int s, a;
    press(B_START, 1'b1, 1'b0, 4'd0, s);
    // Raise cnt_full just before the edge where the prescaler would wrap.
    repeat (9) @(negedge clk);
    cnt_full = 1'b1;
    @(negedge clk);
    checks++;
    if (paused_LED !== 1'b1 || started_LED !== 1'b1) begin
      errors++;
      $display("FAIL saturate_pause: got paused %b started %b, required 1 1", paused_LED, started_LED);
    end
    press(B_PAUSE, 1'b0, 1'b0, 4'd0, a);
    checks++;
    if (paused_LED !== 1'b1) begin
      errors++;
      $display("FAIL saturate_resume_ignored: got paused %b, required 1", paused_LED);
    end
    cnt_full = 1'b0;
    press(B_PAUSE, 1'b0, 1'b0, 4'd0, a);
    // Prescaler held at CLK_DIV-1, so the wrap is on the very next edge.
    exp_tick.push_back(a + 1);
    repeat (2) @(negedge clk);
    #1;
    btn[0] = 1'b1;
    rst_n  = 1'b0;
    #1;
    checks++;
    if ({cnt_tick, cnt_clr, wr_en, wr_addr, rd_addr, sel_recall,
         started_LED, paused_LED, write_LED, mode_LED} !== 16'b0) begin
      errors++;
      $display("FAIL async_reset: got %b, required all zero",
               {cnt_tick, cnt_clr, wr_en, wr_addr, rd_addr, sel_recall,
                started_LED, paused_LED, write_LED, mode_LED});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (started_LED !== 1'b0) begin
      errors++;
      $display("FAIL held_through_reset: got started %b, required 0", started_LED);
    end
    btn[0] = 1'b0;
    repeat (2) @(negedge clk);
    press(B_START, 1'b1, 1'b0, 4'd0, a);
    checks++;
    if (started_LED !== 1'b1) begin
      errors++;
      $display("FAIL start_after_reset: got started %b, required 1", started_LED);
    end
    press(B_START, 1'b0, 1'b0, 4'd0, a);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_tick.size() != 0 || exp_clr.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL saturation_drain: pending tick %0d clr %0d wr %0d, required 0 0 0",
               exp_tick.size(), exp_clr.size(), exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_start_tick_stop();
    test_pause_resume();
    test_record();
    test_recall();
    test_simultaneous();
    test_saturation_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sw_ctrl.md
# sw_ctrl

Control FSM for the stopwatch datapath. It turns the four debounced pushbutton levels into single press events and sequences the centisecond time counter through idle, run and pause. It also arbitrates the lap register file between record (write) and recall (read), and drives the status LEDs. It sits between the `pbdebounce` instances and the counter and lap-register datapath, and feeds the display selection in the top level.

## Interface
- `CLK_DIV`, 500000: clk cycles per counter tick (50 MHz to 100 Hz); must be ≥ 2.
- `NREGS`, 10: number of implemented lap registers; valid addresses are 0..NREGS-1, with NREGS ≤ 16.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: debounced level; a rising edge is a start/stop press.
- `pause_resume` in 1: debounced level; a rising edge is a pause/resume press.
- `record_recall` in 1: debounced level; a rising edge is a record/recall press.
- `recall_mode` in 1: debounced level; a rising edge toggles record/recall mode.
- `reg_address` in 4: lap register address from the switches.
- `cnt_full` in 1: datapath counter is at its maximum value.
- `cnt_tick` out 1: one-cycle increment pulse to the counter.
- `cnt_clr` out 1: one-cycle synchronous clear to the counter.
- `wr_en` out 1: one-cycle lap register write strobe.
- `wr_addr` out 4: lap write address, valid while `wr_en` is high.
- `rd_addr` out 4: latched lap read address.
- `sel_recall` out 1: 1 = display the lap register at `rd_addr`; 0 = display the live counter.
- `reg_exceed` out 1: combinational; high when `reg_address` ≥ NREGS.
- `started_LED`, `paused_LED`, `write_LED`, `mode_LED` out 1 each: status LEDs.

## Operation
- **Press detection:**
  - Each button input passes through a sample register and a history register.
  - A press occurs when sample = 1 and history = 0.
  - Both registers reset to 1, so a button held through reset does not produce a press.
- **Priority:**
  - At most one press is acted on per cycle, in the order start > pause > record > mode.
  - Lower-priority presses detected in the same cycle are discarded.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE + start → RUN, with `cnt_clr` pulsed and the prescaler set to 0.
  - RUN + start → IDLE. The count is held, not cleared.
  - RUN + pause → PAUSE.
  - RUN with `cnt_full` = 1 → PAUSE, with no tick issued that cycle.
  - PAUSE + pause → RUN, unless `cnt_full` = 1, in which case the FSM stays in PAUSE.
  - PAUSE + start → IDLE.
  - IDLE + pause: ignored.
- **Prescaler:**
  - Counts 0..CLK_DIV-1 only in RUN; held in PAUSE and IDLE.
  - `cnt_tick` = 1 for the cycle in which the prescaler wraps from CLK_DIV-1 to 0.
- **Mode flag:**
  - Reset value 0 (record mode).
  - A mode press toggles it and clears `sel_recall`.
  - `mode_LED` = mode flag.
- **Record press, mode 0:**
  - Allowed in any FSM state.
  - If `reg_exceed` = 0: `wr_en` pulses for one cycle with `wr_addr` = `reg_address`, and the `write_LED` flag is set.
  - If `reg_exceed` = 1: no write, and the `write_LED` flag is left unchanged.
- **Record press, mode 1:**
  - If `reg_exceed` = 0: `rd_addr` ← `reg_address` and `sel_recall` ← 1.
  - If `reg_exceed` = 1: no change.
- **Clearing flags:**
  - Any start or pause press that is acted on clears `sel_recall` and the `write_LED` flag.
  - A mode press also clears the `write_LED` flag.
- **LEDs:**
  - `started_LED` = (state ≠ IDLE).
  - `paused_LED` = (state == PAUSE).
- **Address changes:** changing `reg_address` while `sel_recall` = 1 does not change `rd_addr`.

## Timing
- **Reset values:**
  - state IDLE, prescaler 0, mode 0.
  - `rd_addr` 0.
  - `cnt_tick`, `cnt_clr`, `wr_en`, `sel_recall` all 0.
  - All LEDs 0; `wr_addr` 0.
- **Press latency:**
  - An input rises before edge k and is captured in the sample register at edge k.
  - The press is acted on at edge k+1.
  - All resulting registered outputs change after edge k+1.
- **RUN entry:**
  - `cnt_clr` is high for exactly the first cycle in RUN.
  - The first `cnt_tick` occurs CLK_DIV cycles after RUN entry.
  - Subsequent ticks are every CLK_DIV cycles while in RUN.
- **Pause and resume:** time already accumulated in the prescaler is preserved across PAUSE, so a resumed run loses no partial tick.
- **Asynchronous reset mid-operation:**
  - All outputs go to their reset values immediately, with no glitch pulse on `wr_en` or `cnt_clr`.
  - The counter itself is not cleared by this block until the next start.
- **Pulse width:** `wr_en`, `cnt_clr` and `cnt_tick` are always exactly one cycle wide and never assert in two consecutive cycles from a single press.

## Test plan
- **Start, tick and stop:** reset, start press, run 3·CLK_DIV cycles → `cnt_clr` high for 1 cycle after edge k+1 and exactly 3 `cnt_tick` pulses; then a stop press → `started_LED` = 0 and no further ticks.
- **Pause and resume:** CLK_DIV = 10. Pause at prescaler = 6, hold 50 cycles, then resume → the next tick arrives 4 cycles after the RUN re-entry edge; `paused_LED` is high only during the hold.
- **Record with address check:** record mode, `reg_address` = 3 → `wr_en` for 1 cycle, `wr_addr` = 3, `write_LED` = 1. Then `reg_address` = 12 with NREGS = 10 → `reg_exceed` = 1 and no `wr_en`.
- **Recall:** mode press gives `mode_LED` = 1. Record press with `reg_address` = 5 → `sel_recall` = 1 and `rd_addr` = 5. Switching to address 7 leaves `rd_addr` = 5. A pause press clears `sel_recall`.
- **Simultaneous presses:** start and record rising in the same cycle while IDLE, record mode → RUN with `cnt_clr`, and no `wr_en`.
- **Saturation and reset:** `cnt_full` asserted in RUN → PAUSE with no tick. A resume press is ignored. Button held through reset release → no press. `rst_n` low mid-run → all outputs 0 asynchronously.
